load_reservation_station: RTL and testbench

- In-order load queue sitting directly upstream of the load unit.
- Accepts load micro-ops from dispatch with operands either ready or tagged.
- Snoops the CDB to capture pending operands.
- Issues the oldest load to the load unit once both operands are valid, then holds it until the memory response returns before retiring the entry. Only one load is outstanding at a time.

---
 rtl/load_reservation_station_pkg.sv | 34 +++
 rtl/load_reservation_station_if.sv | 47 ++++
 rtl/load_reservation_station_capture.sv | 23 ++
 rtl/load_reservation_station.sv | 203 ++++++++++++++++++++
 tb/tb_load_reservation_station.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_reservation_station_pkg.sv
// rtl/load_reservation_station_pkg.sv - shared types for the load reservation station
// Contents: RS_tag_type, INVALID tag, ls_entry_t queue entry, lrs_state_e FSM states,
// tag_hit() helper used by the operand capture logic.
package load_reservation_station_pkg;

  localparam int TAG_W = 5;

  typedef logic [TAG_W-1:0] RS_tag_type;

  // Tag value meaning "no producer" / "no broadcast this cycle".
  localparam RS_tag_type INVALID = '0;

  typedef enum logic {
    LRS_IDLE,
    LRS_ISSUE
  } lrs_state_e;

  typedef struct packed {
    logic       valid;
    logic [31:0] v1;
    logic       v1_valid;
    RS_tag_type q1;
    logic [31:0] v2;
    logic       v2_valid;
    RS_tag_type q2;
    RS_tag_type rd_tag;
    logic [2:0] mem_type;
  } ls_entry_t;

  function automatic logic tag_hit(input RS_tag_type q, input RS_tag_type cdb);
    return (cdb != INVALID) && (q == cdb);
  endfunction

endpackage

// File: rtl/load_reservation_station_if.sv
// rtl/load_reservation_station_if.sv - dispatch / CDB / load-unit / memory bundle
// Ports (signals): disp_* dispatch handshake and operands, cdb_* result broadcast,
// lu_* issued load, mem_resp_valid, flush, count. slave = station, master = environment.
interface load_reservation_station_if #(
  parameter int DEPTH = 4
);
  import load_reservation_station_pkg::*;

  logic                   disp_valid;
  logic                   disp_ready;
  logic [31:0]            disp_v1;
  logic [31:0]            disp_v2;
  logic                   disp_v1_valid;
  logic                   disp_v2_valid;
  RS_tag_type             disp_q1;
  RS_tag_type             disp_q2;
  RS_tag_type             disp_rd_tag;
  logic [2:0]             disp_mem_type;
  RS_tag_type             cdb_tag;
  logic [31:0]            cdb_val;
  logic [31:0]            lu_V1;
  logic [31:0]            lu_V2;
  logic                   lu_V1_valid;
  logic                   lu_V2_valid;
  RS_tag_type             lu_rd_tag;
  logic [2:0]             lu_mem_type;
  logic                   mem_resp_valid;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;

  modport slave (
    input  disp_valid, disp_v1, disp_v2, disp_v1_valid, disp_v2_valid,
           disp_q1, disp_q2, disp_rd_tag, disp_mem_type,
           cdb_tag, cdb_val, mem_resp_valid, flush,
    output disp_ready, lu_V1, lu_V2, lu_V1_valid, lu_V2_valid,
           lu_rd_tag, lu_mem_type, count
  );

  modport master (
    output disp_valid, disp_v1, disp_v2, disp_v1_valid, disp_v2_valid,
           disp_q1, disp_q2, disp_rd_tag, disp_mem_type,
           cdb_tag, cdb_val, mem_resp_valid, flush,
    input  disp_ready, lu_V1, lu_V2, lu_V1_valid, lu_V2_valid,
           lu_rd_tag, lu_mem_type, count
  );

endinterface

// File: rtl/load_reservation_station_capture.sv
// rtl/load_reservation_station_capture.sv - single-operand CDB wakeup (lrs_operand_capture)
// Ports: val/val_valid/q current operand, cdb_tag/cdb_val broadcast,
// val_out/val_valid_out operand after this cycle's broadcast is applied.
module lrs_operand_capture
  import load_reservation_station_pkg::*;
(
  input  logic [31:0] val,
  input  logic        val_valid,
  input  RS_tag_type  q,
  input  RS_tag_type  cdb_tag,
  input  logic [31:0] cdb_val,
  output logic [31:0] val_out,
  output logic        val_valid_out
);

  logic hit;

  // An operand that already holds a value never gets overwritten by a later broadcast.
  assign hit           = !val_valid && tag_hit(q, cdb_tag);
  assign val_out       = hit ? cdb_val : val;
  assign val_valid_out = val_valid | hit;

endmodule

// File: rtl/load_reservation_station.sv
// rtl/load_reservation_station.sv - in-order load queue with CDB wakeup, one load outstanding
// Ports: CLK, RST_N (async active-low), bus (load_reservation_station_if.slave):
// dispatch push, CDB snoop, registered load-unit issue, memory response, flush, count.
module load_reservation_station
  import load_reservation_station_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                      CLK,
  input logic                      RST_N,
  load_reservation_station_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  ls_entry_t        ent [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_r;
  lrs_state_e       state;
  lrs_state_e       next_state;

  logic [31:0] cap_v1 [DEPTH];
  logic [31:0] cap_v2 [DEPTH];
  logic        cap_v1_valid [DEPTH];
  logic        cap_v2_valid [DEPTH];

  logic [31:0] d_v1, d_v2;
  logic        d_v1_valid, d_v2_valid;

  logic        push, pop, issue, disp_ready_w;

  // Head candidate as seen after this cycle's CDB broadcast and dispatch.
  logic        hd_valid, hd_v1_valid, hd_v2_valid, head_ready;
  logic [31:0] hd_v1, hd_v2;
  RS_tag_type  hd_rd_tag;
  logic [2:0]  hd_mem_type;

  logic        lu_valid_q;
  logic [31:0] lu_v1_q, lu_v2_q;
  RS_tag_type  lu_tag_q;
  logic [2:0]  lu_mt_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry_cap
    lrs_operand_capture u_cap_v1 (
      .val(ent[i].v1), .val_valid(ent[i].v1_valid), .q(ent[i].q1),
      .cdb_tag(bus.cdb_tag), .cdb_val(bus.cdb_val),
      .val_out(cap_v1[i]), .val_valid_out(cap_v1_valid[i])
    );
    lrs_operand_capture u_cap_v2 (
      .val(ent[i].v2), .val_valid(ent[i].v2_valid), .q(ent[i].q2),
      .cdb_tag(bus.cdb_tag), .cdb_val(bus.cdb_val),
      .val_out(cap_v2[i]), .val_valid_out(cap_v2_valid[i])
    );
  end

  // Dispatch bypass: a broadcast in the same cycle as the push is not lost.
  lrs_operand_capture u_disp_cap_v1 (
    .val(bus.disp_v1), .val_valid(bus.disp_v1_valid), .q(bus.disp_q1),
    .cdb_tag(bus.cdb_tag), .cdb_val(bus.cdb_val),
    .val_out(d_v1), .val_valid_out(d_v1_valid)
  );
  lrs_operand_capture u_disp_cap_v2 (
    .val(bus.disp_v2), .val_valid(bus.disp_v2_valid), .q(bus.disp_q2),
    .cdb_tag(bus.cdb_tag), .cdb_val(bus.cdb_val),
    .val_out(d_v2), .val_valid_out(d_v2_valid)
  );

  assign disp_ready_w = (count_r != CNT_W'(DEPTH));
  assign push         = bus.disp_valid && disp_ready_w && !bus.flush;

  // With an empty queue the incoming load becomes the head at this edge, so it
  // can issue straight from the dispatch path for a push-to-issue latency of 1.
  always_comb begin
    hd_valid    = 1'b0;
    hd_v1       = '0;
    hd_v1_valid = 1'b0;
    hd_v2       = '0;
    hd_v2_valid = 1'b0;
    hd_rd_tag   = INVALID;
    hd_mem_type = '0;
    if (ent[head].valid) begin
      hd_valid    = 1'b1;
      hd_v1       = cap_v1[head];
      hd_v1_valid = cap_v1_valid[head];
      hd_v2       = cap_v2[head];
      hd_v2_valid = cap_v2_valid[head];
      hd_rd_tag   = ent[head].rd_tag;
      hd_mem_type = ent[head].mem_type;
    end else if (push) begin
      hd_valid    = 1'b1;
      hd_v1       = d_v1;
      hd_v1_valid = d_v1_valid;
      hd_v2       = d_v2;
      hd_v2_valid = d_v2_valid;
      hd_rd_tag   = bus.disp_rd_tag;
      hd_mem_type = bus.disp_mem_type;
    end
  end

  assign head_ready = hd_valid && hd_v1_valid && hd_v2_valid;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= LRS_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    pop        = 1'b0;
    if (bus.flush) begin
      next_state = LRS_IDLE;
    end else begin
      case (state)
        LRS_IDLE: begin
          if (head_ready) begin
            next_state = LRS_ISSUE;
            issue      = 1'b1;
          end
        end
        LRS_ISSUE: begin
          if (bus.mem_resp_valid) begin
            next_state = LRS_IDLE;
            pop        = 1'b1;
          end
        end
        default: next_state = LRS_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent[i].valid) begin
          ent[i].v1       <= cap_v1[i];
          ent[i].v1_valid <= cap_v1_valid[i];
          ent[i].v2       <= cap_v2[i];
          ent[i].v2_valid <= cap_v2_valid[i];
        end
      end
      if (pop) begin
        ent[head].valid <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      // Pop and push never target the same slot: a push needs a free slot.
      if (push) begin
        ent[tail] <= '{valid: 1'b1, v1: d_v1, v1_valid: d_v1_valid, q1: bus.disp_q1,
                       v2: d_v2, v2_valid: d_v2_valid, q2: bus.disp_q2,
                       rd_tag: bus.disp_rd_tag, mem_type: bus.disp_mem_type};
        tail      <= tail + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lu_valid_q <= 1'b0;
      lu_v1_q    <= '0;
      lu_v2_q    <= '0;
      lu_tag_q   <= INVALID;
      lu_mt_q    <= '0;
    end else if (bus.flush || pop) begin
      lu_valid_q <= 1'b0;
      lu_v1_q    <= '0;
      lu_v2_q    <= '0;
      lu_tag_q   <= INVALID;
      lu_mt_q    <= '0;
    end else if (issue) begin
      lu_valid_q <= 1'b1;
      lu_v1_q    <= hd_v1;
      lu_v2_q    <= hd_v2;
      lu_tag_q   <= hd_rd_tag;
      lu_mt_q    <= hd_mem_type;
    end
  end

  assign bus.disp_ready  = disp_ready_w;
  assign bus.count       = count_r;
  assign bus.lu_V1       = lu_v1_q;
  assign bus.lu_V2       = lu_v2_q;
  assign bus.lu_V1_valid = lu_valid_q;
  assign bus.lu_V2_valid = lu_valid_q;
  assign bus.lu_rd_tag   = lu_tag_q;
  assign bus.lu_mem_type = lu_mt_q;

endmodule

// File: tb/tb_load_reservation_station.sv
// tb/tb_load_reservation_station.sv - scoreboard bench for load_reservation_station
module tb_load_reservation_station;
  import load_reservation_station_pkg::*;

  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  load_reservation_station_if #(.DEPTH(DEPTH)) bus ();

  load_reservation_station #(.DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [31:0] v1;
    bit          ok1;
    RS_tag_type  q1;
    logic [31:0] v2;
    bit          ok2;
    RS_tag_type  q2;
    RS_tag_type  tag;
    logic [2:0]  mt;
  } mload_t;

  int     n_checks = 0;
  int     n_pass = 0;
  bit     mon_en = 0;
  bit     m_issued = 0;
  mload_t mq[$];
  mload_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic set_idle();
    bus.disp_valid     = 1'b0;
    bus.disp_v1        = '0;
    bus.disp_v2        = '0;
    bus.disp_v1_valid  = 1'b0;
    bus.disp_v2_valid  = 1'b0;
    bus.disp_q1        = INVALID;
    bus.disp_q2        = INVALID;
    bus.disp_rd_tag    = INVALID;
    bus.disp_mem_type  = '0;
    bus.cdb_tag        = INVALID;
    bus.cdb_val        = '0;
    bus.mem_resp_valid = 1'b0;
    bus.flush          = 1'b0;
  endtask

  task automatic dispatch(input logic [31:0] v1, input bit ok1, input RS_tag_type q1,
                          input logic [31:0] v2, input bit ok2, input RS_tag_type q2,
                          input RS_tag_type tag, input logic [2:0] mt);
    bus.disp_valid    = 1'b1;
    bus.disp_v1       = v1;
    bus.disp_v1_valid = ok1;
    bus.disp_q1       = q1;
    bus.disp_v2       = v2;
    bus.disp_v2_valid = ok2;
    bus.disp_q2       = q2;
    bus.disp_rd_tag   = tag;
    bus.disp_mem_type = mt;
  endtask

  function automatic void model_reset();
    mq.delete();
    exp_q.delete();
    m_issued = 0;
  endfunction

  // Reference behaviour at one clock edge, from the inputs held during the cycle.
  function automatic void model_update();
    bit     was_full;
    bit     popped;
    mload_t e;
    if (bus.flush) begin
      model_reset();
      return;
    end
    was_full = (mq.size() == DEPTH);
    if (bus.cdb_tag != INVALID) begin
      foreach (mq[i]) begin
        if (!mq[i].ok1 && mq[i].q1 == bus.cdb_tag) begin mq[i].v1 = bus.cdb_val; mq[i].ok1 = 1; end
        if (!mq[i].ok2 && mq[i].q2 == bus.cdb_tag) begin mq[i].v2 = bus.cdb_val; mq[i].ok2 = 1; end
      end
    end
    popped = 0;
    if (m_issued && bus.mem_resp_valid) begin
      void'(mq.pop_front());
      m_issued = 0;
      popped = 1;
    end
    if (bus.disp_valid && !was_full) begin
      e.v1 = bus.disp_v1; e.ok1 = bus.disp_v1_valid; e.q1 = bus.disp_q1;
      e.v2 = bus.disp_v2; e.ok2 = bus.disp_v2_valid; e.q2 = bus.disp_q2;
      e.tag = bus.disp_rd_tag; e.mt = bus.disp_mem_type;
      if (!e.ok1 && bus.cdb_tag != INVALID && e.q1 == bus.cdb_tag) begin e.v1 = bus.cdb_val; e.ok1 = 1; end
      if (!e.ok2 && bus.cdb_tag != INVALID && e.q2 == bus.cdb_tag) begin e.v2 = bus.cdb_val; e.ok2 = 1; end
      mq.push_back(e);
    end
    if (!m_issued && !popped && mq.size() > 0 && mq[0].ok1 && mq[0].ok2) begin
      m_issued = 1;
      exp_q.push_back(mq[0]);
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (mq.size() != 0 && k < 200) begin
      set_idle();
      bus.cdb_tag        = RS_tag_type'((k % 15) + 1);
      bus.cdb_val        = $urandom;
      bus.mem_resp_valid = m_issued;
      tick();
      k++;
    end
    set_idle();
    chk("drain_empty", 32'(mq.size()), 32'd0);
  endtask

  // Monitor: per-cycle state checks plus scoreboard pop on each new issue.
  bit     prev_v = 0;
  mload_t got_e;
  always @(negedge CLK) begin
    if (!RST_N || !mon_en) begin
      prev_v = 0;
    end else begin
      chk("count", 32'(bus.count), 32'(mq.size()));
      chk("disp_ready", 32'(bus.disp_ready), 32'(mq.size() != DEPTH));
      chk("lu_V1_valid", 32'(bus.lu_V1_valid), 32'(m_issued));
      chk("lu_V2_valid", 32'(bus.lu_V2_valid), 32'(m_issued));
      if (!bus.lu_V1_valid) chk("idle_rd_tag", 32'(bus.lu_rd_tag), 32'(INVALID));
      if (bus.lu_V1_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("issue_expected", 32'd1, 32'd0);
        end else begin
          got_e = exp_q.pop_front();
          chk("issue_V1", bus.lu_V1, got_e.v1);
          chk("issue_V2", bus.lu_V2, got_e.v2);
          chk("issue_rd_tag", 32'(bus.lu_rd_tag), 32'(got_e.tag));
          chk("issue_mem_type", 32'(bus.lu_mem_type), 32'(got_e.mt));
        end
      end
      prev_v = bus.lu_V1_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    set_idle();
    RST_N = 1'b0;
    #1;
    chk("rst_lu_V1_valid", 32'(bus.lu_V1_valid), 32'd0);
    chk("rst_lu_V1", bus.lu_V1, 32'd0);
    chk("rst_lu_rd_tag", 32'(bus.lu_rd_tag), 32'(INVALID));
    chk("rst_disp_ready", 32'(bus.disp_ready), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RST_N = 1'b1;
    mon_en = 1;

    // 1: both operands ready, issue next cycle
    dispatch(32'h1000, 1, INVALID, 32'h4, 1, INVALID, 5'd3, 3'b010);
    tick();
    set_idle();
    chk("t1_valid", 32'(bus.lu_V1_valid), 32'd1);
    chk("t1_V1", bus.lu_V1, 32'h1000);
    chk("t1_V2", bus.lu_V2, 32'h4);
    chk("t1_tag", 32'(bus.lu_rd_tag), 32'd3);
    tick(); tick(); tick();
    bus.mem_resp_valid = 1'b1;
    tick();
    set_idle();
    chk("t1_count_after", 32'(bus.count), 32'd0);
    chk("t1_valid_after", 32'(bus.lu_V1_valid), 32'd0);

    // 2: CDB wakeup; an INVALID broadcast is ignored
    dispatch(32'h0, 0, 5'd5, 32'h4, 1, INVALID, 5'd4, 3'b001);
    tick();
    set_idle();
    tick(); tick();
    chk("t2_no_issue", 32'(bus.lu_V1_valid), 32'd0);
    bus.cdb_tag = INVALID;
    bus.cdb_val = 32'h2000;
    tick();
    set_idle();
    chk("t2_invalid_bcast", 32'(bus.lu_V1_valid), 32'd0);
    bus.cdb_tag = 5'd5;
    bus.cdb_val = 32'h2000;
    tick();
    set_idle();
    chk("t2_woken", 32'(bus.lu_V1_valid), 32'd1);
    chk("t2_V1", bus.lu_V1, 32'h2000);
    drain();

    // 3: same-cycle dispatch bypass
    dispatch(32'h100, 1, INVALID, 32'h0, 0, 5'd7, 5'd6, 3'b100);
    bus.cdb_tag = 5'd7;
    bus.cdb_val = 32'h8;
    tick();
    set_idle();
    chk("t3_valid", 32'(bus.lu_V1_valid), 32'd1);
    chk("t3_V2", bus.lu_V2, 32'h8);
    drain();

    // 4: full queue with unready head; strict in-order drain
    dispatch(32'h0, 0, 5'd9, 32'h10, 1, INVALID, 5'd10, 3'b000);
    tick();
    for (int i = 0; i < 3; i++) begin
      dispatch(32'h200 + 32'(i), 1, INVALID, 32'h20, 1, INVALID, RS_tag_type'(11 + i), 3'b011);
      tick();
    end
    set_idle();
    chk("t4_full_ready", 32'(bus.disp_ready), 32'd0);
    chk("t4_no_issue", 32'(bus.lu_V1_valid), 32'd0);
    dispatch(32'h300, 1, INVALID, 32'h30, 1, INVALID, 5'd14, 3'b011);
    tick();
    set_idle();
    chk("t4_push_blocked", 32'(bus.count), 32'd4);
    bus.cdb_tag = 5'd9;
    bus.cdb_val = 32'h9000;
    tick();
    set_idle();
    bus.mem_resp_valid = 1'b1;
    tick();
    set_idle();
    chk("t4_ready_after_pop", 32'(bus.disp_ready), 32'd1);
    drain();

    // 5: flush with a same-cycle response
    dispatch(32'h40, 1, INVALID, 32'h8, 1, INVALID, 5'd20, 3'b110);
    tick();
    dispatch(32'h44, 1, INVALID, 32'h8, 1, INVALID, 5'd21, 3'b110);
    tick();
    set_idle();
    bus.mem_resp_valid = 1'b1;
    bus.flush = 1'b1;
    tick();
    set_idle();
    chk("t5_count", 32'(bus.count), 32'd0);
    chk("t5_valid", 32'(bus.lu_V1_valid), 32'd0);

    // 6: asynchronous reset between edges while issuing
    dispatch(32'h50, 1, INVALID, 32'h4, 1, INVALID, 5'd22, 3'b010);
    tick();
    set_idle();
    tick();
    #3;
    RST_N = 1'b0;
    #1;
    model_reset();
    chk("t6_valid", 32'(bus.lu_V1_valid), 32'd0);
    chk("t6_V1", bus.lu_V1, 32'd0);
    chk("t6_tag", 32'(bus.lu_rd_tag), 32'(INVALID));
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_ready", 32'(bus.disp_ready), 32'd1);
    @(posedge CLK);
    #2;
    RST_N = 1'b1;
    dispatch(32'h60, 1, INVALID, 32'h4, 1, INVALID, 5'd23, 3'b001);
    tick();
    set_idle();
    chk("t6_fresh_issue", 32'(bus.lu_V1_valid), 32'd1);
    drain();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      set_idle();
      if ($urandom_range(0, 2) != 0) begin
        dispatch($urandom, $urandom_range(0, 2) != 0, RS_tag_type'($urandom_range(1, 7)),
                 $urandom, $urandom_range(0, 2) != 0, RS_tag_type'($urandom_range(1, 7)),
                 RS_tag_type'($urandom_range(1, 31)), 3'($urandom_range(0, 7)));
      end
      bus.cdb_tag        = RS_tag_type'($urandom_range(0, 7));
      bus.cdb_val        = $urandom;
      bus.mem_resp_valid = ($urandom_range(0, 2) == 0);
      bus.flush          = ($urandom_range(0, 63) == 0);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
